// File: rtl/video_mem_arbiter.sv
// Video memory arbiter: grants the shared video read port to either the
// shifter or the viking in the video bus slot. One read is outstanding at a
// time; read data is captured a fixed latency after the slot start.
module video_mem_arbiter #(
    parameter logic [1:0]  VIDEO_SLOT   = 2'd1,
    parameter int unsigned READ_LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  bus_cycle_i,
    input  logic        viking_enable_i,
    input  logic        sh_req_i,
    input  logic [22:0] sh_addr_i,
    output logic        sh_ack_o,
    output logic [63:0] sh_data_o,
    output logic        sh_valid_o,
    input  logic        vk_req_i,
    input  logic [22:0] vk_addr_i,
    output logic        vk_ack_o,
    output logic [63:0] vk_data_o,
    output logic        vk_valid_o,
    output logic [22:0] mem_addr_o,
    output logic        mem_read_o,
    input  logic [63:0] mem_data_i,
    output logic        owner_o,
    output logic        busy_o
);

    localparam logic [2:0] RL = 3'(READ_LATENCY);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_e;

    state_e      state_q, state_d;
    logic [1:0]  prev_bc_q;
    logic        owner_q, owner_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        mem_read_q, mem_read_d;
    logic [22:0] mem_addr_q, mem_addr_d;
    logic        sh_ack_q, sh_ack_d, vk_ack_q, vk_ack_d;
    logic        sh_valid_q, sh_valid_d, vk_valid_q, vk_valid_d;
    logic [63:0] sh_data_q, sh_data_d, vk_data_q, vk_data_d;

    logic        slot_start;
    logic        own_req;
    logic [22:0] own_addr;
    logic [2:0]  cnt_inc;

    // Slot start is the first clk of a run of VIDEO_SLOT phases.
    assign slot_start = (bus_cycle_i == VIDEO_SLOT) && (prev_bc_q != VIDEO_SLOT);
    assign own_req    = owner_q ? vk_req_i  : sh_req_i;
    assign own_addr   = owner_q ? vk_addr_i : sh_addr_i;
    assign cnt_inc    = cnt_q + 3'd1;

    // Next-state and registered-output logic of the arbitration FSM.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        mem_read_d = 1'b0;
        mem_addr_d = mem_addr_q;
        sh_ack_d   = 1'b0;
        vk_ack_d   = 1'b0;
        sh_valid_d = 1'b0;
        vk_valid_d = 1'b0;
        sh_data_d  = sh_data_q;
        vk_data_d  = vk_data_q;
        unique case (state_q)
            IDLE: begin
                if (slot_start && own_req) begin
                    // Owner is frozen for the whole transaction.
                    state_d    = ISSUE;
                    cnt_d      = 3'd0;
                    mem_read_d = 1'b1;
                    mem_addr_d = own_addr;
                    if (owner_q) vk_ack_d = 1'b1;
                    else         sh_ack_d = 1'b1;
                end else begin
                    owner_d = viking_enable_i;
                end
            end
            ISSUE, WAIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc == RL) begin
                    // Latency reached: capture wins over a still-open slot.
                    state_d = DELIVER;
                    if (owner_q) begin
                        vk_data_d  = mem_data_i;
                        vk_valid_d = 1'b1;
                    end else begin
                        sh_data_d  = mem_data_i;
                        sh_valid_d = 1'b1;
                    end
                end else if (state_q == ISSUE && bus_cycle_i == VIDEO_SLOT) begin
                    mem_read_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            DELIVER: begin
                // Never issue here, even on a coinciding slot start.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            prev_bc_q  <= ~VIDEO_SLOT;
            owner_q    <= 1'b0;
            cnt_q      <= 3'd0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            sh_ack_q   <= 1'b0;
            vk_ack_q   <= 1'b0;
            sh_valid_q <= 1'b0;
            vk_valid_q <= 1'b0;
            sh_data_q  <= '0;
            vk_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_bc_q  <= bus_cycle_i;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
            sh_ack_q   <= sh_ack_d;
            vk_ack_q   <= vk_ack_d;
            sh_valid_q <= sh_valid_d;
            vk_valid_q <= vk_valid_d;
            sh_data_q  <= sh_data_d;
            vk_data_q  <= vk_data_d;
        end
    end

    assign sh_ack_o   = sh_ack_q;
    assign vk_ack_o   = vk_ack_q;
    assign sh_valid_o = sh_valid_q;
    assign vk_valid_o = vk_valid_q;
    assign sh_data_o  = sh_data_q;
    assign vk_data_o  = vk_data_q;
    assign mem_read_o = mem_read_q;
    assign mem_addr_o = mem_addr_q;
    assign owner_o    = owner_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Bench for video_mem_arbiter: directed vector table, corner-case sequences
// and randomized traffic against a transaction-timeline reference model.
module tb_video_mem_arbiter;

    localparam logic [1:0] SLOT = 2'd1;
    localparam int         RL   = 3;
    localparam logic [22:0] A = 23'h012345, B = 23'h7ABCDE;
    localparam logic [63:0] D1 = 64'hDEADBEEF_CAFEF00D, D2 = 64'h01234567_89ABCDEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ven, sh_req, vk_req;
    logic [1:0]  bus_cycle;
    logic [22:0] sh_addr, vk_addr, mem_addr;
    logic [63:0] mem_data, sh_data, vk_data;
    logic        sh_ack, sh_valid, vk_ack, vk_valid, mem_read, owner, busy;

    int checks = 0, failures = 0;

    video_mem_arbiter #(.VIDEO_SLOT(SLOT), .READ_LATENCY(RL)) dut (
        .clk_i(clk), .reset_i(reset), .bus_cycle_i(bus_cycle), .viking_enable_i(ven),
        .sh_req_i(sh_req), .sh_addr_i(sh_addr), .sh_ack_o(sh_ack), .sh_data_o(sh_data),
        .sh_valid_o(sh_valid), .vk_req_i(vk_req), .vk_addr_i(vk_addr), .vk_ack_o(vk_ack),
        .vk_data_o(vk_data), .vk_valid_o(vk_valid), .mem_addr_o(mem_addr),
        .mem_read_o(mem_read), .mem_data_i(mem_data), .owner_o(owner), .busy_o(busy)
    );

    typedef struct {
        logic sha, shv, vka, vkv, mr, busy, own;
        logic [22:0] ma;
        logic [63:0] shd, vkd;
    } out_t;

    typedef struct {
        logic rst; logic [1:0] bc; logic ven, shr, vkr; logic [63:0] md;
        out_t e;
    } vec_t;

    // Reference model: a transaction is described by its age k in clocks
    // since the issuing slot start (-1 = none outstanding).
    out_t       m;
    logic [1:0] m_prev;
    int         k = -1;
    logic       txo;

    task automatic model_edge();
        logic slot;
        if (reset) begin
            m = '{default: '0};
            m_prev = ~SLOT;
            k = -1;
        end else begin
            slot = (bus_cycle == SLOT) && (m_prev != SLOT);
            m.sha = 0; m.vka = 0; m.shv = 0; m.vkv = 0;
            if (k < 0) begin
                if (slot && (m.own ? vk_req : sh_req)) begin
                    k = 0; txo = m.own; m.mr = 1;
                    m.ma = m.own ? vk_addr : sh_addr;
                    if (txo) m.vka = 1; else m.sha = 1;
                end else m.own = ven;
            end else begin
                k++;
                if (k == RL) begin
                    m.mr = 0;
                    if (txo) begin m.vkv = 1; m.vkd = mem_data; end
                    else     begin m.shv = 1; m.shd = mem_data; end
                end else if (k == RL + 1) k = -1;
                else m.mr = m.mr && (bus_cycle == SLOT);
            end
            m.busy = (k >= 0);
            m_prev = bus_cycle;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_out(input string tag, input out_t e);
        chk({tag, " sh_ack"},   64'(sh_ack),   64'(e.sha));
        chk({tag, " sh_valid"}, 64'(sh_valid), 64'(e.shv));
        chk({tag, " vk_ack"},   64'(vk_ack),   64'(e.vka));
        chk({tag, " vk_valid"}, 64'(vk_valid), 64'(e.vkv));
        chk({tag, " mem_read"}, 64'(mem_read), 64'(e.mr));
        chk({tag, " busy"},     64'(busy),     64'(e.busy));
        chk({tag, " owner"},    64'(owner),    64'(e.own));
        chk({tag, " mem_addr"}, 64'(mem_addr), 64'(e.ma));
        chk({tag, " sh_data"},  sh_data,       e.shd);
        chk({tag, " vk_data"},  vk_data,       e.vkd);
    endtask

    // One clock: model follows the sampled inputs, outputs checked 1 ns later.
    task automatic step(input bit use_model);
        @(posedge clk);
        model_edge();
        #1;
        if (use_model) cmp_out("model", m);
    endtask

    task automatic tick(input logic [1:0] bc);
        bus_cycle = bc;
        mem_data  = {$urandom, $urandom};
        step(1);
    endtask

    function automatic vec_t V(logic rst, logic [1:0] bc, logic v, logic shr, logic vkr,
                               logic [63:0] md, logic sha, logic shv, logic vka, logic vkv,
                               logic mr, logic bsy, logic own, logic [22:0] ma,
                               logic [63:0] shd, logic [63:0] vkd);
        vec_t r;
        r.rst = rst; r.bc = bc; r.ven = v; r.shr = shr; r.vkr = vkr; r.md = md;
        r.e = '{sha, shv, vka, vkv, mr, bsy, own, ma, shd, vkd};
        return r;
    endfunction

    vec_t vt[15];
    int   cnt;

    initial begin
        reset = 1; bus_cycle = 0; ven = 0; sh_req = 0; vk_req = 0;
        sh_addr = A; vk_addr = B; mem_data = 0;

        //        rst bc ven shr vkr md  | sha shv vka vkv mr bsy own ma shd vkd
        vt[0]  = V(1, 0, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0,  0);
        vt[1]  = V(0, 0, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0,  0);
        vt[2]  = V(0, 1, 0, 1, 0, 0,    1, 0, 0, 0, 1, 1, 0, A, 0,  0);
        vt[3]  = V(0, 2, 0, 1, 0, 0,    0, 0, 0, 0, 0, 1, 0, A, 0,  0);
        vt[4]  = V(0, 3, 0, 1, 0, 0,    0, 0, 0, 0, 0, 1, 0, A, 0,  0);
        vt[5]  = V(0, 0, 0, 1, 0, D1,   0, 1, 0, 0, 0, 1, 0, A, D1, 0);
        vt[6]  = V(0, 1, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0, A, D1, 0);
        vt[7]  = V(0, 2, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0, A, D1, 0);
        vt[8]  = V(0, 3, 1, 1, 1, 0,    0, 0, 0, 0, 0, 0, 1, A, D1, 0);
        vt[9]  = V(0, 0, 1, 1, 1, 0,    0, 0, 0, 0, 0, 0, 1, A, D1, 0);
        vt[10] = V(0, 1, 1, 1, 1, 0,    0, 0, 1, 0, 1, 1, 1, B, D1, 0);
        vt[11] = V(0, 2, 1, 1, 1, 0,    0, 0, 0, 0, 0, 1, 1, B, D1, 0);
        vt[12] = V(0, 3, 1, 1, 1, 0,    0, 0, 0, 0, 0, 1, 1, B, D1, 0);
        vt[13] = V(0, 0, 1, 1, 1, D2,   0, 0, 0, 1, 0, 1, 1, B, D1, D2);
        vt[14] = V(0, 1, 1, 1, 1, 0,    0, 0, 0, 0, 0, 0, 1, B, D1, D2);

        for (int i = 0; i < 15; i++) begin
            reset = vt[i].rst; bus_cycle = vt[i].bc; ven = vt[i].ven;
            sh_req = vt[i].shr; vk_req = vt[i].vkr; mem_data = vt[i].md;
            step(0);
            cmp_out($sformatf("vec%0d", i), vt[i].e);
        end

        // Owner switch while busy: shifter still gets its data.
        ven = 0; sh_req = 1; vk_req = 1; sh_addr = 23'($urandom); vk_addr = 23'($urandom);
        tick(2); tick(3); tick(0); tick(1);
        chk("sw sh_ack", 64'(sh_ack), 64'd1);
        ven = 1;
        tick(2); chk("sw owner held", 64'(owner), 64'd0);
        tick(3); tick(0); chk("sw sh_valid", 64'(sh_valid), 64'd1);
        tick(1); tick(2); chk("sw owner new", 64'(owner), 64'd1);
        tick(3); tick(0); tick(1);
        chk("sw vk_ack", 64'(vk_ack), 64'd1);
        chk("sw sh_ack quiet", 64'(sh_ack), 64'd0);
        tick(2); tick(3); tick(0); tick(1);

        // Reset during WAIT abandons the read.
        ven = 0;
        tick(2); tick(3); tick(0); tick(1); tick(2);
        reset = 1; tick(3);
        chk("rst mem_read", 64'(mem_read), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        reset = 0; cnt = 0;
        tick(0); cnt += int'(sh_valid);
        tick(1); cnt += int'(sh_valid);
        chk("rst no sh_valid", 64'(cnt), 64'd0);
        tick(2); tick(3); tick(0); tick(1);

        // Late request misses its slot and goes at the next one.
        sh_req = 0;
        tick(2); tick(3); tick(0); tick(1);
        chk("late no ack", 64'(sh_ack), 64'd0);
        chk("late no read", 64'(mem_read), 64'd0);
        sh_req = 1;
        tick(2); chk("late ack mid", 64'(sh_ack), 64'd0);
        tick(3); tick(0); tick(1);
        chk("late ack next", 64'(sh_ack), 64'd1);
        tick(2); tick(3); tick(0); tick(1);

        // Slot phase held for two clocks: one read spanning both.
        sh_addr = 23'($urandom);
        tick(2); tick(3); tick(0); tick(1);
        tick(1);
        chk("hold mem_read", 64'(mem_read), 64'd1);
        chk("hold mem_addr", 64'(mem_addr), 64'(sh_addr));
        chk("hold one ack", 64'(sh_ack), 64'd0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick(2'(2 + i));
            cnt += int'(sh_valid);
        end
        chk("hold one valid", 64'(cnt), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            reset   = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) ven = ~ven;
            sh_req  = ($urandom_range(0, 9) < 7);
            vk_req  = ($urandom_range(0, 9) < 7);
            sh_addr = 23'($urandom);
            vk_addr = 23'($urandom);
            tick(($urandom_range(0, 4) == 0) ? bus_cycle : bus_cycle + 2'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
